// File: rtl/keycode_arbiter.sv
// keycode_arbiter
//   Turns raw 6-slot USB HID keyboard reports into per-frame movement and
//   fire keycodes for the player-motion block.
//   - keycode1 is the most recently pressed movement key that is still held.
//   - keycode0 is the next most recent held movement key.
//   - keycodeshoot is a rate-limited fire strobe.
//
// Ports
//   frame_clk     in   1   frame clock; all state updates on posedge
//   Reset         in   1   synchronous, active-high
//   report_valid  in   1   keycode_rpt holds a new report this cycle
//   keycode_rpt   in   48  six HID slots, slot i = bits [8i+7:8i], 8'h00 = empty
//   keycode0      out  8   second-most-recent held movement key, 8'h00 if none
//   keycode1      out  8   most-recent held movement key, 8'h00 if none
//   keycodeshoot  out  8   SHOOT_KEY for exactly one frame per fire, else 8'h00
//   depth         out  3   number of movement keys currently held (0..4)
module keycode_arbiter #(
    parameter logic [7:0] KEY_A          = 8'h04,
    parameter logic [7:0] KEY_D          = 8'h07,
    parameter logic [7:0] KEY_S          = 8'h16,
    parameter logic [7:0] KEY_W          = 8'h1A,
    parameter logic [7:0] SHOOT_KEY      = 8'h2C,
    parameter logic [3:0] SHOOT_COOLDOWN = 4'd3,
    parameter logic [7:0] TIMEOUT        = 8'd60
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        report_valid,
    input  logic [47:0] keycode_rpt,
    output logic [7:0]  keycode0,
    output logic [7:0]  keycode1,
    output logic [7:0]  keycodeshoot,
    output logic [2:0]  depth
);

    // Press-order stack: entry 0 is the most recent press. Unused entries
    // are kept at 8'h00 so they can drive the outputs directly.
    logic [3:0][7:0] stack, stack_n;
    logic [2:0]      depth_n;
    logic            shoot_held, shoot_held_n;
    logic [3:0]      cooldown, cooldown_n;
    logic [7:0]      tcount, tcount_n;
    logic [7:0]      shoot_n;

    logic            rollover;
    logic            take;

    function automatic logic is_move(input logic [7:0] code);
        return (code == KEY_A) || (code == KEY_D) || (code == KEY_S) || (code == KEY_W);
    endfunction

    function automatic logic in_report(input logic [7:0] code, input logic [47:0] rpt);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < 6; s++)
            if (rpt[8*s +: 8] == code) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic in_stack(input logic [7:0] code, input logic [3:0][7:0] stk);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++)
            if (stk[i] == code) hit = 1'b1;
        return hit;
    endfunction

    // A phantom-key rollover report (every slot 8'h01) carries no key
    // information, so it is handled exactly like an idle frame.
    assign rollover = (keycode_rpt == {6{8'h01}});
    assign take     = report_valid && !rollover;

    // NOTE: every variable written here is given a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        logic [3:0][7:0] tmp;
        logic [2:0]      cnt;
        logic [7:0]      code;

        stack_n      = stack;
        depth_n      = depth;
        shoot_held_n = shoot_held;
        tcount_n     = tcount;
        tmp          = '0;
        cnt          = '0;
        code         = '0;

        if (take) begin
            tcount_n     = '0;
            shoot_held_n = in_report(SHOOT_KEY, keycode_rpt);

            // Removals first: keep surviving entries in their original order.
            for (int i = 0; i < 4; i++) begin
                if ((3'(i) < depth) && in_report(stack[i], keycode_rpt)) begin
                    tmp[cnt[1:0]] = stack[i];
                    cnt           = cnt + 3'd1;
                end
            end

            // Then pushes in slot order, so the highest new slot lands on top.
            // Checking against tmp also collapses duplicate slots.
            for (int s = 0; s < 6; s++) begin
                code = keycode_rpt[8*s +: 8];
                if (is_move(code) && !in_stack(code, tmp)) begin
                    tmp = {tmp[2:0], code};
                    cnt = cnt + 3'd1;
                end
            end

            stack_n = tmp;
            depth_n = cnt;
        end else begin
            if (tcount != TIMEOUT)
                tcount_n = tcount + 8'd1;
            if (tcount_n == TIMEOUT) begin
                stack_n      = '0;
                depth_n      = '0;
                shoot_held_n = 1'b0;
            end
        end

        // Fire uses the freshly updated hold flag; cooldown runs independently
        // of the key so a quick re-press cannot beat the repeat period.
        if (shoot_held_n && (cooldown == 4'd0)) begin
            shoot_n    = SHOOT_KEY;
            cooldown_n = SHOOT_COOLDOWN;
        end else begin
            shoot_n    = 8'h00;
            cooldown_n = (cooldown != 4'd0) ? cooldown - 4'd1 : 4'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            stack        <= '0;
            depth        <= '0;
            shoot_held   <= 1'b0;
            cooldown     <= '0;
            tcount       <= '0;
            keycodeshoot <= 8'h00;
        end else begin
            stack        <= stack_n;
            depth        <= depth_n;
            shoot_held   <= shoot_held_n;
            cooldown     <= cooldown_n;
            tcount       <= tcount_n;
            keycodeshoot <= shoot_n;
        end
    end

    assign keycode1 = stack[0];
    assign keycode0 = stack[1];

endmodule
